// File: rtl/count_capture_pkg.sv
// count_capture_pkg: shared sizing and entry layout for the counter capture
// block. A stored entry is packed as {first, stamp, delta}, MSB to LSB.
package count_capture_pkg;

  localparam int CNT_W_DEF = 32;
  localparam int DEPTH_DEF = 4;
  localparam int ENTRY_W   = 2 * CNT_W_DEF + 1;

  // Field layout helpers, usable with any counter width.
  function automatic int entry_w(input int cnt_w);
    return 2 * cnt_w + 1;
  endfunction

  function automatic int delta_lsb(input int cnt_w);
    return 0 * cnt_w;
  endfunction

  function automatic int stamp_lsb(input int cnt_w);
    return cnt_w;
  endfunction

  function automatic int first_bit(input int cnt_w);
    return 2 * cnt_w;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: first-word-fall-through circular buffer.
//   clk, rst      : clock, async active-high reset
//   clear_i       : synchronous flush; overrides push_i/pop_i
//   push_i, din_i : write request and data (dropped when full without a pop)
//   pop_i         : remove head entry (ignored when empty)
//   dout_o        : head entry; holds the last shown value while empty
//   count_o       : number of stored entries, 0..DEPTH
module sync_fifo_fwft #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  dout_o,
  output logic [CW-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]  wr_q, rd_q, used;
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] hold_q;
  logic         empty, full, pop_ok, push_ok;

  assign used    = wr_q - rd_q;
  assign empty   = (used == '0);
  assign full    = (used == (AW+1)'(DEPTH));
  assign pop_ok  = pop_i & ~empty & ~clear_i;
  assign push_ok = push_i & (~full | pop_ok) & ~clear_i;
  assign count_o = CW'(used);

  assign dout_o = empty ? hold_q : mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      hold_q <= '0;
    end else begin
      hold_q <= dout_o;
      if (clear_i) begin
        wr_q <= '0;
        rd_q <= '0;
      end else begin
        if (push_ok) wr_q <= wr_q + ONE;
        if (pop_ok)  rd_q <= rd_q + ONE;
      end
    end
  end

  // Storage needs no reset: it is only read while non-empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/count_capture.sv
// count_capture: samples a free-running counter on rising edges of event_in,
// computes the elapsed count since the previous stored capture and queues
// {first, stamp, delta} entries on a valid/ready stream.
//   clk, rst            : clock, async active-high reset
//   cnt_in              : free-running counter value
//   event_in            : event level; capture on its rising edge
//   clear               : flush the queue, clear overflow, re-arm first
//   out_valid/out_ready : output handshake (first-word-fall-through)
//   out_stamp/out_delta : head entry counter sample and elapsed count
//   out_first           : head entry is first since reset/clear (delta 0)
//   overflow            : sticky, a capture was dropped
//   level               : stored entry count
module count_capture
  import count_capture_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int LVL_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cnt_in,
  input  logic             event_in,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_stamp,
  output logic [CNT_W-1:0] out_delta,
  output logic             out_first,
  output logic             overflow,
  output logic [LVL_W-1:0] level
);

  localparam int EW = entry_w(CNT_W);
  localparam int DL = delta_lsb(CNT_W);
  localparam int SL = stamp_lsb(CNT_W);
  localparam int FB = first_bit(CNT_W);

  logic             event_q, armed_q, overflow_q;
  logic             armed_d, overflow_d;
  logic [CNT_W-1:0] last_q, last_d;
  logic             rise, pop, push, full;
  logic [EW-1:0]    din, dout;

  assign rise = event_in & ~event_q & ~clear;
  assign full = (level == LVL_W'(DEPTH));
  // Derived from the registered count only, so out_ready never reaches out_valid.
  assign out_valid = (level != '0);
  assign pop  = out_valid & out_ready & ~clear;
  // A full queue still takes the capture when the head leaves this cycle.
  assign push = rise & (~full | pop);

  always_comb begin
    din             = '0;
    din[FB]         = armed_q;
    din[SL +: CNT_W] = cnt_in;
    din[DL +: CNT_W] = armed_q ? '0 : cnt_in - last_q;
  end

  always_comb begin
    armed_d    = armed_q;
    overflow_d = overflow_q;
    last_d     = last_q;
    if (clear) begin
      armed_d    = 1'b1;
      overflow_d = 1'b0;
    end else if (push) begin
      armed_d = 1'b0;
      last_d  = cnt_in;
    end else if (rise) begin
      // Dropped capture leaves the delta chain untouched.
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      event_q    <= 1'b1;
      armed_q    <= 1'b1;
      overflow_q <= 1'b0;
      last_q     <= '0;
    end else begin
      event_q    <= event_in;
      armed_q    <= armed_d;
      overflow_q <= overflow_d;
      last_q     <= last_d;
    end
  end

  sync_fifo_fwft #(.W(EW), .DEPTH(DEPTH), .CW(LVL_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear_i (clear),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (din),
    .dout_o  (dout),
    .count_o (level)
  );

  assign overflow  = overflow_q;
  assign out_first = dout[FB];
  assign out_stamp = dout[SL +: CNT_W];
  assign out_delta = dout[DL +: CNT_W];

endmodule

// File: tb/tb_count_capture.sv
module tb_count_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cnt_in;
  logic        event_in, clear, out_ready;
  logic        out_valid, out_first, overflow;
  logic [31:0] out_stamp, out_delta;
  logic [2:0]  level;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        first;
    logic [31:0] stamp;
    logic [31:0] delta;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  count_capture #(.CNT_W(32), .DEPTH(4), .LVL_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .cnt_in    (cnt_in),
    .event_in  (event_in),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_stamp (out_stamp),
    .out_delta (out_delta),
    .out_first (out_first),
    .overflow  (overflow),
    .level     (level)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One clock with the given inputs; returns 1 time unit after the edge.
  task automatic cyc(input logic ev, input logic rdy, input logic [31:0] c,
                     input logic clr = 1'b0);
    event_in  = ev;
    out_ready = rdy;
    cnt_in    = c;
    clear     = clr;
    @(posedge clk);
    #1;
  endtask

  // Low then high: capture lands on the edge where cnt_in == c.
  task automatic rise(input logic [31:0] c, input logic rdy);
    cyc(1'b0, rdy, c - 32'd1);
    cyc(1'b1, rdy, c);
  endtask

  task automatic expect_entry(input logic f, input logic [31:0] s, input logic [31:0] d);
    exp_t e;
    e.first = f;
    e.stamp = s;
    e.delta = d;
    q.push_back(e);
  endtask

  task automatic drain(input int n);
    repeat (n) cyc(1'b0, 1'b1, 32'd0);
  endtask

  // Scoreboard: every handshake the DUT completes is checked against the queue.
  always @(negedge clk) begin
    if (!rst && !clear && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_pop", {out_first, out_stamp}, 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("first", out_first, e.first);
        chk("stamp", out_stamp, e.stamp);
        chk("delta", out_delta, e.delta);
      end
    end
  end

  initial begin
    rst = 1'b1; event_in = 1'b1; clear = 1'b0; out_ready = 1'b0; cnt_in = 32'd0;
    #2;
    chk("rst_level", level, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_stamp", out_stamp, 0);
    chk("rst_delta", out_delta, 0);
    chk("rst_first", out_first, 0);
    @(posedge clk); #1;
    cyc(1'b1, 1'b1, 32'd0);
    rst = 1'b0;
    // event_in stays high across reset release: no capture.
    repeat (3) cyc(1'b1, 1'b1, 32'd0);
    chk("held_high_level", level, 0);
    chk("held_high_valid", out_valid, 0);

    // Basic captures at 100 and 350, one-cycle latency.
    cyc(1'b0, 1'b1, 32'd99);
    chk("pre_valid", out_valid, 0);
    cyc(1'b1, 1'b1, 32'd100);
    expect_entry(1'b1, 32'd100, 32'd0);
    chk("lat_valid1", out_valid, 1);
    cyc(1'b0, 1'b1, 32'd349);
    chk("drained1", out_valid, 0);
    cyc(1'b1, 1'b1, 32'd350);
    expect_entry(1'b0, 32'd350, 32'd250);
    chk("lat_valid2", out_valid, 1);

    // Counter wrap.
    rise(32'hFFFF_FFF0, 1'b1);
    expect_entry(1'b0, 32'hFFFF_FFF0, 32'hFFFF_FE92);
    rise(32'h0000_0010, 1'b1);
    expect_entry(1'b0, 32'h0000_0010, 32'h0000_0020);
    drain(2);
    chk("wrap_level", level, 0);

    // Overflow: six captures into a four-deep queue.
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    rise(32'd10, 1'b0); expect_entry(1'b1, 32'd10, 32'd0);
    rise(32'd20, 1'b0); expect_entry(1'b0, 32'd20, 32'd10);
    rise(32'd30, 1'b0); expect_entry(1'b0, 32'd30, 32'd10);
    chk("ovf_not_yet", overflow, 0);
    rise(32'd40, 1'b0); expect_entry(1'b0, 32'd40, 32'd10);
    rise(32'd50, 1'b0);
    rise(32'd60, 1'b0);
    chk("ovf_level", level, 4);
    chk("ovf_flag", overflow, 1);
    drain(4);
    chk("ovf_drained", level, 0);
    rise(32'd70, 1'b1); expect_entry(1'b0, 32'd70, 32'd30);
    drain(2);
    chk("ovf_sticky", overflow, 1);

    // Full queue with a simultaneous pop still accepts the capture.
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    chk("clr_ovf", overflow, 0);
    rise(32'd100, 1'b0); expect_entry(1'b1, 32'd100, 32'd0);
    rise(32'd110, 1'b0); expect_entry(1'b0, 32'd110, 32'd10);
    rise(32'd120, 1'b0); expect_entry(1'b0, 32'd120, 32'd10);
    rise(32'd130, 1'b0); expect_entry(1'b0, 32'd130, 32'd10);
    chk("full_level", level, 4);
    cyc(1'b0, 1'b0, 32'd139);
    cyc(1'b1, 1'b1, 32'd140);
    expect_entry(1'b0, 32'd140, 32'd10);
    cyc(1'b0, 1'b0, 32'd141);
    chk("fullpop_level", level, 4);
    chk("fullpop_ovf", overflow, 0);
    drain(5);
    chk("fullpop_drained", level, 0);

    // clear with three entries and overflow set, plus a rise in the same cycle.
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    rise(32'd200, 1'b0); expect_entry(1'b1, 32'd200, 32'd0);
    rise(32'd210, 1'b0); expect_entry(1'b0, 32'd210, 32'd10);
    rise(32'd220, 1'b0); expect_entry(1'b0, 32'd220, 32'd10);
    rise(32'd230, 1'b0); expect_entry(1'b0, 32'd230, 32'd10);
    rise(32'd240, 1'b0);
    cyc(1'b0, 1'b1, 32'd245);
    chk("pre_clr_level", level, 3);
    chk("pre_clr_ovf", overflow, 1);
    cyc(1'b0, 1'b0, 32'd249);
    cyc(1'b1, 1'b1, 32'd250, 1'b1);
    q.delete();
    chk("clr_level", level, 0);
    chk("clr_ovf2", overflow, 0);
    chk("clr_valid", out_valid, 0);
    rise(32'd300, 1'b1); expect_entry(1'b1, 32'd300, 32'd0);
    drain(2);

    // Async reset mid-burst.
    rise(32'd400, 1'b0); expect_entry(1'b0, 32'd400, 32'd100);
    rise(32'd410, 1'b0); expect_entry(1'b0, 32'd410, 32'd10);
    chk("burst_level", level, 2);
    #2 rst = 1'b1;
    #1;
    chk("async_valid", out_valid, 0);
    chk("async_level", level, 0);
    q.delete();
    cyc(1'b0, 1'b0, 32'd0);
    rst = 1'b0;
    rise(32'd500, 1'b1); expect_entry(1'b1, 32'd500, 32'd0);
    drain(3);
    chk("final_level", level, 0);
    chk("q_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/count_capture.md
Name: count_capture

Overview:
- Consumer/reader side of the free-running 32-bit counter: samples the counter value on rising edges of an event line.
- For each accepted capture, computes the modulo elapsed count since the previous accepted capture.
- Stores {first, stamp, delta} entries in a small FIFO.
- Presents entries on a valid/ready output stream for software or a downstream logger.

Parameters:
- CNT_W, 32: width of counter input, stamp and delta.
- DEPTH, 4: FIFO entries; power of two, minimum 2.
- LVL_W, 3: width of level output; must equal clog2(DEPTH+1).

Ports:
- clk, input, 1: single clock; all logic on posedge.
- rst, input, 1: asynchronous, active-high reset.
- cnt_in, input, CNT_W: free-running counter value, synchronous to clk.
- event_in, input, 1: synchronous event level; a capture occurs on its rising edge.
- clear, input, 1: synchronous flush and re-arm.
- out_valid, output, 1: head entry available.
- out_ready, input, 1: consumer accepts head entry.
- out_stamp, output, CNT_W: head entry counter sample.
- out_delta, output, CNT_W: head entry elapsed count since the previous accepted capture.
- out_first, output, 1: head entry is the first capture since reset or clear; its delta is 0.
- overflow, output, 1: sticky; at least one capture was dropped.
- level, output, LVL_W: number of stored entries, 0..DEPTH.

Behaviour:
- Reset (async, rst=1):
  - level=0, out_valid=0, overflow=0.
  - out_stamp/out_delta/out_first=0.
  - last_stamp=0, armed_first=1.
  - Internal event_q=1, so a line already high at reset release does not capture until it goes low and high again.
- Edge detect:
  - rise = event_in & ~event_q, evaluated in the current cycle.
  - event_q <= event_in every cycle, including cycles with clear asserted.
- Capture on rise at posedge N:
  - stamp = cnt_in as sampled at posedge N.
  - delta = (cnt_in - last_stamp) mod 2^CNT_W. Wrap-around is handled naturally: last=0xFFFFFFF0, cnt=0x00000010 gives delta=0x20.
  - If armed_first: first=1, delta=0, then armed_first<=0.
- Accept rule:
  - A push is accepted if level<DEPTH, or if a pop occurs in the same cycle (full with simultaneous pop is accepted).
  - On accept: entry written, last_stamp<=stamp.
  - On reject: entry dropped, overflow<=1, last_stamp and armed_first unchanged. Deltas of stored entries therefore always chain consecutively.
- Latency: entry visible on the out_* ports in cycle N+1 if the FIFO was empty; out_valid rises at posedge N.
- Output stream (first-word-fall-through):
  - out_valid = (level!=0).
  - out_* always show the head entry.
  - Pop occurs when out_valid & out_ready at a posedge.
  - out_* hold stable while out_valid=1 and out_ready=0.
  - out_* are don't-care when out_valid=0; RTL holds the last values.
- level: +1 on accepted push, -1 on pop, unchanged when both occur.
- clear (highest priority after rst):
  - level<=0, overflow<=0, armed_first<=1.
  - A rise in the same cycle is ignored.
  - A pop in the same cycle is ignored; out_ready is don't-care.
- Reset mid-operation: all state returns to reset values immediately; in-flight entries are lost.
- No combinational path from out_ready to out_valid.

Decomposition:
- Shared package/include count_capture_pkg:
  - ENTRY_W = 2*CNT_W+1.
  - Field offsets for first/stamp/delta in the packed entry.
  - Default CNT_W=32 and DEPTH=4.
- One sub-module, sync_fifo_fwft:
  - Parameterised width/depth, circular buffer.
  - Read/write pointers one bit wider than the address for full/empty detection.
  - Push/pop/clear inputs; count output.
- count_capture owns edge detect, delta arithmetic, first/overflow logic and the accept rule.

Test Plan:
- Reset, then cnt_in counting from 0; event_in rise at cnt=100 then at cnt=350, out_ready=1 -> entry {first=1, stamp=100, delta=0}, then {first=0, stamp=350, delta=250}; each appears 1 cycle after its capture edge.
- Wrap: event_in rises at cnt=0xFFFFFFF0 and then at 0x00000010 -> second entry delta=0x20.
- Overflow with DEPTH=4, out_ready=0: 6 rises at cnt=10, 20, 30, 40, 50, 60 -> level=4, overflow=1; drain yields stamps 10/20/30/40, deltas 0/10/10/10; next rise at 70 gives delta 30.
- Full plus simultaneous pop: level=4, rise and out_ready=1 in the same cycle -> push accepted, level stays 4, overflow stays 0.
- clear with 3 entries and overflow=1, plus a rise in the same cycle -> level=0, overflow=0, no entry written; next rise produces first=1, delta=0.
- event_in held high across rst deassertion -> no capture until event_in goes low then high; async rst asserted mid-burst -> out_valid=0 and level=0 immediately, without waiting for a clock edge.
